dll_replay_buffer: RTL and testbench

Parametrised transmit-side replay buffer for the PCIe Data Link Layer, sitting between the TL-to-DLL write path and the PIPE TX arbiter. It assigns 12-bit sequence numbers to TLPs and holds every transmitted TLP until it is acknowledged. On NAK or replay-timer expiry it replays all unacknowledged TLPs in order, and it requests link retrain after repeated replays. Depth, width and replay policy are parameters; replay timing is a compile-time option.

---
 rtl/dll_replay_buffer.sv | 258 +++++++++++++++++++++++++
 tb/tb_dll_replay_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_replay_buffer.sv
// PCIe Data Link Layer transmit replay buffer: TLP sequence numbering, ACK/NAK purge and in-order replay.
// Compile-time option: define DLL_REPLAY_TIMER_EN to build the replay timer; without it only NAK triggers replay.
module dll_replay_buffer #(
  parameter int DATA_WIDTH     = 256,
  parameter int DEPTH_LG2      = 6,
  parameter int SEQ_WIDTH      = 12,
  parameter int REPLAY_TIMEOUT = 1024,
  parameter int REPLAY_NUM_MAX = 3
) (
  input  logic                  sclk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] tlp_data_i,
  input  logic                  tlp_valid_i,
  input  logic                  tlp_sop_i,
  input  logic                  tlp_eop_i,
  output logic                  tlp_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  output logic                  tx_sop_o,
  output logic                  tx_eop_o,
  output logic [SEQ_WIDTH-1:0]  tx_seq_o,
  input  logic                  tx_ready_i,
  input  logic                  acknak_valid_i,
  input  logic                  acknak_is_nak_i,
  input  logic [SEQ_WIDTH-1:0]  acknak_seq_i,
  output logic [DEPTH_LG2:0]    free_cnt_o,
  output logic                  replaying_o,
  output logic                  dllp_err_o,
  output logic                  retrain_req_o
);

  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int PW    = DEPTH_LG2 + 1;
  localparam int NUM_W = $clog2(REPLAY_NUM_MAX + 1);

  localparam logic [PW-1:0]        PTR_ONE  = 1;
  localparam logic [PW-1:0]        FULL_CNT = {1'b1, {DEPTH_LG2{1'b0}}};
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE  = 1;
  localparam logic [NUM_W-1:0]     NUM_ONE  = 1;
  localparam logic [NUM_W-1:0]     NUM_MAX  = REPLAY_NUM_MAX[NUM_W-1:0];

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_PURGE  = 2'd2;
  localparam logic [1:0] ST_REPLAY = 2'd3;

  if (REPLAY_TIMEOUT < 1 || REPLAY_NUM_MAX < 1) begin : g_bad_cfg
    $error("dll_replay_buffer: REPLAY_TIMEOUT and REPLAY_NUM_MAX must both be at least 1");
  end

  // Beat storage
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic                  r_mem_sop  [DEPTH];
  logic                  r_mem_eop  [DEPTH];
  logic [SEQ_WIDTH-1:0]  r_mem_seq  [DEPTH];

  // Pointers carry a wrap bit so full and empty are distinguishable
  logic [PW-1:0]        r_head, r_rd, r_commit, r_wr, r_replay_end;
  logic [SEQ_WIDTH-1:0] r_next_seq, r_cur_seq, r_ackd_seq;
  logic [1:0]           r_state;
  logic [NUM_W-1:0]     r_replay_num;
  logic                 r_nak_pend;
  logic                 r_dllp_err, r_retrain;

  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid, r_tx_sop, r_tx_eop;
  logic [SEQ_WIDTH-1:0]  r_tx_seq;
  logic                  r_in_tlp;

  logic [PW-1:0]        w_level;
  logic                 w_wr_fire;
  logic [SEQ_WIDTH-1:0] w_wr_seq;
  logic [SEQ_WIDTH-1:0] w_out_cnt, w_d_new, w_head_off;
  logic                 w_ack_ok, w_ack_err, w_nak, w_progress;
  logic                 w_head_acked, w_purge;
  logic                 w_timer_exp, w_trigger;
  logic                 w_out_free, w_idle_out;
  logic                 w_can_send, w_tx_load;
  logic [1:0]           w_state_nxt;
  logic                 w_enter_purge, w_leave_purge;
  logic [DEPTH_LG2-1:0] w_rd_idx, w_wr_idx, w_head_idx;

  assign w_rd_idx   = r_rd[DEPTH_LG2-1:0];
  assign w_wr_idx   = r_wr[DEPTH_LG2-1:0];
  assign w_head_idx = r_head[DEPTH_LG2-1:0];

  assign w_level   = r_wr - r_head;
  assign w_wr_fire = tlp_valid_i && tlp_ready_o;
  assign w_wr_seq  = tlp_sop_i ? r_next_seq : r_cur_seq;

  // Outstanding window is (ackd_seq, next_seq-1]; anything outside it is acknowledged.
  assign w_out_cnt  = r_next_seq - r_ackd_seq - SEQ_ONE;
  assign w_d_new    = acknak_seq_i - r_ackd_seq;
  assign w_ack_ok   = acknak_valid_i && (w_d_new <= w_out_cnt);
  assign w_ack_err  = acknak_valid_i && !(w_d_new <= w_out_cnt);
  assign w_nak      = w_ack_ok && acknak_is_nak_i;
  assign w_progress = w_ack_ok && (w_d_new != '0);

  assign w_head_off   = r_mem_seq[w_head_idx] - r_ackd_seq - SEQ_ONE;
  assign w_head_acked = (w_head_off >= w_out_cnt);
  assign w_purge      = ((r_state == ST_NORMAL) || (r_state == ST_PURGE)) &&
                        (r_head != r_rd) && w_head_acked;

`ifdef DLL_REPLAY_TIMER_EN
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = REPLAY_TIMEOUT[TW-1:0];
  localparam logic [TW-1:0] TMR_ONE   = 1;

  logic [TW-1:0] r_timer;

  assign w_timer_exp = (r_state == ST_NORMAL) && (r_timer == TIMEOUT_V);

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_timer <= '0;
    end else if ((r_state != ST_NORMAL) || w_progress || (r_head == r_rd)) begin
      r_timer <= '0;
    end else if (!w_timer_exp) begin
      r_timer <= r_timer + TMR_ONE;
    end
  end
`else
  assign w_timer_exp = 1'b0;
`endif

  // A NAK coinciding with timer expiry lands in the same trigger and counts once.
  assign w_trigger  = r_nak_pend || w_timer_exp;
  assign w_out_free = !r_tx_valid || tx_ready_i;
  assign w_idle_out = !r_in_tlp && w_out_free;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_can_send  = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        w_can_send = w_trigger ? r_in_tlp : (r_rd != r_commit);
        if (w_trigger) w_state_nxt = w_idle_out ? ST_PURGE : ST_DRAIN;
      end
      ST_DRAIN: begin
        w_can_send = r_in_tlp;
        if (w_idle_out) w_state_nxt = ST_PURGE;
      end
      ST_PURGE: begin
        if (!w_purge) w_state_nxt = (r_head == r_replay_end) ? ST_NORMAL : ST_REPLAY;
      end
      ST_REPLAY: begin
        w_can_send = (r_rd != r_replay_end);
        if ((r_rd == r_replay_end) && w_out_free) w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  assign w_tx_load     = w_can_send && w_out_free;
  assign w_enter_purge = (r_state != ST_PURGE) && (w_state_nxt == ST_PURGE);
  assign w_leave_purge = (r_state == ST_PURGE) && (w_state_nxt != ST_PURGE);

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge sclk) begin
    if (w_wr_fire) begin
      r_mem_data[w_wr_idx] <= tlp_data_i;
      r_mem_sop[w_wr_idx]  <= tlp_sop_i;
      r_mem_eop[w_wr_idx]  <= tlp_eop_i;
      r_mem_seq[w_wr_idx]  <= w_wr_seq;
    end
  end

  // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_head       <= '0;
      r_rd         <= '0;
      r_commit     <= '0;
      r_wr         <= '0;
      r_replay_end <= '0;
      r_next_seq   <= '0;
      r_cur_seq    <= '0;
      r_ackd_seq   <= '1;
      r_state      <= ST_NORMAL;
      r_replay_num <= '0;
      r_nak_pend   <= 1'b0;
      r_dllp_err   <= 1'b0;
      r_retrain    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dllp_err <= w_ack_err;
      r_retrain  <= 1'b0;

      if (w_purge) r_head <= r_head + PTR_ONE;

      if (w_wr_fire) begin
        r_wr <= r_wr + PTR_ONE;
        if (tlp_eop_i) r_commit <= r_wr + PTR_ONE;
        if (tlp_sop_i) begin
          r_next_seq <= r_next_seq + SEQ_ONE;
          r_cur_seq  <= r_next_seq;
        end
      end

      if (w_ack_ok) r_ackd_seq <= acknak_seq_i;

      if (w_leave_purge)  r_rd <= r_head;
      else if (w_tx_load) r_rd <= r_rd + PTR_ONE;

      if (w_enter_purge) begin
        r_replay_end <= r_rd;
        if (r_replay_num == NUM_MAX) begin
          r_replay_num <= '0;
          r_retrain    <= 1'b1;
        end else begin
          r_replay_num <= r_replay_num + NUM_ONE;
        end
      end else if (w_progress) begin
        r_replay_num <= '0;
      end

      // NAKs seen while already draining or purging are covered by the replay under way.
      if ((r_state == ST_NORMAL) && (w_state_nxt != ST_NORMAL)) begin
        r_nak_pend <= 1'b0;
      end else if (w_nak && ((r_state == ST_NORMAL) || (r_state == ST_REPLAY))) begin
        r_nak_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_seq   <= '0;
      r_in_tlp   <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_valid <= 1'b1;
      r_tx_sop   <= r_mem_sop[w_rd_idx];
      r_tx_eop   <= r_mem_eop[w_rd_idx];
      r_tx_data  <= r_mem_data[w_rd_idx];
      r_tx_seq   <= r_mem_seq[w_rd_idx];
      r_in_tlp   <= !r_mem_eop[w_rd_idx];
    end else if (tx_ready_i) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tlp_ready_o   = (w_level != FULL_CNT);
  assign free_cnt_o    = FULL_CNT - w_level;
  assign tx_data_o     = r_tx_data;
  assign tx_valid_o    = r_tx_valid;
  assign tx_sop_o      = r_tx_sop;
  assign tx_eop_o      = r_tx_eop;
  assign tx_seq_o      = r_tx_seq;
  assign replaying_o   = (r_state != ST_NORMAL);
  assign dllp_err_o    = r_dllp_err;
  assign retrain_req_o = r_retrain;

endmodule

// File: tb/tb_dll_replay_buffer.sv
// Directed self-checking bench for dll_replay_buffer (default parameters, 64-beat buffer).
// Define DLL_REPLAY_TIMER_EN for both files to exercise the timer-driven replay.
module tb_dll_replay_buffer;

  localparam int DW = 256;
  localparam int LG = 6;
  localparam int SW = 12;

  logic          sclk = 1'b0;
  logic          srst = 1'b1;
  logic [DW-1:0] tlp_data_i = '0;
  logic          tlp_valid_i = 1'b0;
  logic          tlp_sop_i = 1'b0;
  logic          tlp_eop_i = 1'b0;
  logic          tlp_ready_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_valid_o, tx_sop_o, tx_eop_o;
  logic [SW-1:0] tx_seq_o;
  logic          tx_ready_i = 1'b0;
  logic          acknak_valid_i = 1'b0;
  logic          acknak_is_nak_i = 1'b0;
  logic [SW-1:0] acknak_seq_i = '0;
  logic [LG:0]   free_cnt_o;
  logic          replaying_o, dllp_err_o, retrain_req_o;

  int n_vec = 0;
  int n_err = 0;

  dll_replay_buffer dut (
    .sclk            (sclk),
    .srst            (srst),
    .tlp_data_i      (tlp_data_i),
    .tlp_valid_i     (tlp_valid_i),
    .tlp_sop_i       (tlp_sop_i),
    .tlp_eop_i       (tlp_eop_i),
    .tlp_ready_o     (tlp_ready_o),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_sop_o        (tx_sop_o),
    .tx_eop_o        (tx_eop_o),
    .tx_seq_o        (tx_seq_o),
    .tx_ready_i      (tx_ready_i),
    .acknak_valid_i  (acknak_valid_i),
    .acknak_is_nak_i (acknak_is_nak_i),
    .acknak_seq_i    (acknak_seq_i),
    .free_cnt_o      (free_cnt_o),
    .replaying_o     (replaying_o),
    .dllp_err_o      (dllp_err_o),
    .retrain_req_o   (retrain_req_o)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic write_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int t;
    t = 0;
    tlp_data_i  = d;
    tlp_sop_i   = s;
    tlp_eop_i   = e;
    tlp_valid_i = 1'b1;
    while (!tlp_ready_o && t < 200) begin
      tick();
      t++;
    end
    if (t == 200) check("wr_ready_timeout", tlp_ready_o, 1'b1);
    tick();
    tlp_valid_i = 1'b0;
    tlp_sop_i   = 1'b0;
    tlp_eop_i   = 1'b0;
  endtask

  task automatic acknak(input logic [SW-1:0] s, input logic nak);
    acknak_valid_i  = 1'b1;
    acknak_is_nak_i = nak;
    acknak_seq_i    = s;
    tick();
    acknak_valid_i  = 1'b0;
    acknak_is_nak_i = 1'b0;
  endtask

  // Send a NAK and follow the replay it causes until the buffer is back in normal operation.
  task automatic nak_replay(input logic [SW-1:0] s, output int n_rt, output int first_seq);
    logic seen;
    logic done;
    n_rt      = 0;
    first_seq = -1;
    seen      = 1'b0;
    done      = 1'b0;
    acknak(s, 1'b1);
    for (int t = 0; t < 100 && !done; t++) begin
      if (retrain_req_o) n_rt++;
      if (replaying_o) seen = 1'b1;
      if (seen && tx_valid_o && tx_sop_o && first_seq < 0) first_seq = int'(tx_seq_o);
      if (seen && !replaying_o && !tx_valid_o) done = 1'b1;
      else tick();
    end
    check("replay_seen", seen, 1'b1);
    check("replay_done", done, 1'b1);
  endtask

  initial begin
    int rt, fs, rt_sum, rep_seq;
    logic seen_rep;

    // Reset state
    tick();
    tick();
    check("rst_tlp_ready", tlp_ready_o, 1'b1);
    check("rst_free_cnt", free_cnt_o, 64);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_replaying", replaying_o, 1'b0);
    check("rst_dllp_err", dllp_err_o, 1'b0);
    check("rst_retrain", retrain_req_o, 1'b0);
    srst = 1'b0;
    tx_ready_i = 1'b1;
    tick();

    // Three back-to-back 2-beat TLPs; sop leaves two cycles after its eop is accepted
    write_beat(256'hA0, 1'b1, 1'b0);
    write_beat(256'hA1, 1'b0, 1'b1);
    check("lat_not_yet", tx_valid_o, 1'b0);
    write_beat(256'hB0, 1'b1, 1'b0);
    check("t0_valid", tx_valid_o, 1'b1);
    check("t0_sop", tx_sop_o, 1'b1);
    check("t0_seq", tx_seq_o, 0);
    check("t0_data", tx_data_o, 256'hA0);
    write_beat(256'hB1, 1'b0, 1'b1);
    check("t0_eop", tx_eop_o, 1'b1);
    check("t0_data1", tx_data_o, 256'hA1);
    write_beat(256'hC0, 1'b1, 1'b0);
    check("t1_sop", tx_sop_o, 1'b1);
    check("t1_seq", tx_seq_o, 1);
    write_beat(256'hC1, 1'b0, 1'b1);
    check("t1_data1", tx_data_o, 256'hB1);
    tick();
    check("t2_sop", tx_sop_o, 1'b1);
    check("t2_seq", tx_seq_o, 2);
    check("t2_data", tx_data_o, 256'hC0);
    tick();
    tick();
    check("sent_idle", tx_valid_o, 1'b0);
    check("free_after_3", free_cnt_o, 58);

    // ACK seq 1 frees TLPs 0 and 1, one beat per cycle starting two cycles after the ACK
    acknak(12'd1, 1'b0);
    check("ack_ok_no_err", dllp_err_o, 1'b0);
    check("ack_free_n1", free_cnt_o, 58);
    tick();
    check("ack_free_n2", free_cnt_o, 59);
    tick();
    tick();
    tick();
    check("ack_free_done", free_cnt_o, 62);
    tick();
    check("ack_free_stable", free_cnt_o, 62);

    // NAK seq 1 replays only TLP 2
    nak_replay(12'd1, rt, fs);
    check("nak1_first_seq", fs, 2);
    check("nak1_no_retrain", rt, 0);
    check("nak1_free", free_cnt_o, 62);

    // Out-of-range ACK: error pulse, no state change
    acknak(12'd5, 1'b0);
    check("bad_ack_err", dllp_err_o, 1'b1);
    tick();
    check("bad_ack_err_pulse", dllp_err_o, 1'b0);
    tick();
    check("bad_ack_no_free", free_cnt_o, 62);
    acknak(12'd2, 1'b0);
    check("ack2_in_range", dllp_err_o, 1'b0);
    repeat (4) tick();
    check("ack2_all_free", free_cnt_o, 64);

    // Reset in the middle of a transfer drops everything at once
    tx_ready_i = 1'b0;
    write_beat(256'hD0, 1'b1, 1'b0);
    write_beat(256'hD1, 1'b0, 1'b1);
    tick();
    check("pre_rst_valid", tx_valid_o, 1'b1);
    srst = 1'b1;
    #1;
    check("mid_rst_valid", tx_valid_o, 1'b0);
    check("mid_rst_free", free_cnt_o, 64);
    check("mid_rst_ready", tlp_ready_o, 1'b1);
    tick();
    srst = 1'b0;
    tx_ready_i = 1'b1;
    tick();

    // REPLAY_NUM: two NAKs, ACK clears, then rollover on the fourth following replay
    write_beat(256'hE0, 1'b1, 1'b0);
    write_beat(256'hE1, 1'b0, 1'b1);
    write_beat(256'hF0, 1'b1, 1'b0);
    write_beat(256'hF1, 1'b0, 1'b1);
    repeat (6) tick();
    check("rn_free", free_cnt_o, 60);
    rt_sum = 0;
    for (int i = 0; i < 2; i++) begin
      nak_replay(12'hFFF, rt, fs);
      rt_sum += rt;
      check("rn_pre_seq", fs, 0);
    end
    acknak(12'd0, 1'b0);
    repeat (4) tick();
    check("rn_ack0_free", free_cnt_o, 62);
    for (int i = 0; i < 3; i++) begin
      nak_replay(12'd0, rt, fs);
      rt_sum += rt;
      check("rn_post_seq", fs, 1);
    end
    check("rn_no_retrain_yet", rt_sum, 0);
    nak_replay(12'd0, rt, fs);
    check("rn_retrain_4th", rt, 1);

    // Fill to 64 beats with the arbiter stalled
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tx_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) write_beat(DW'(100 + i), (i % 2) == 0, (i % 2) == 1);
    check("full_ready", tlp_ready_o, 1'b0);
    check("full_free", free_cnt_o, 0);
    check("full_hold_data", tx_data_o, 100);
    check("full_hold_seq", tx_seq_o, 0);
    check("full_hold_valid", tx_valid_o, 1'b1);
    acknak(12'd31, 1'b0);
    check("full_ack_no_err", dllp_err_o, 1'b0);
    check("full_ack_n1", tlp_ready_o, 1'b0);
    tick();
    check("full_ack_n2_ready", tlp_ready_o, 1'b1);
    check("full_ack_n2_free", free_cnt_o, 1);

    // Unacknowledged TLP with no NAK: replay only when the timer is built
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tx_ready_i = 1'b1;
    tick();
    write_beat(256'h77, 1'b1, 1'b0);
    write_beat(256'h78, 1'b0, 1'b1);
    seen_rep = 1'b0;
    rep_seq = -1;
    for (int i = 0; i < 1100; i++) begin
      if (replaying_o) seen_rep = 1'b1;
      if (seen_rep && tx_valid_o && tx_sop_o && rep_seq < 0) rep_seq = int'(tx_seq_o);
      tick();
    end
`ifdef DLL_REPLAY_TIMER_EN
    check("timer_replay", seen_rep, 1'b1);
    check("timer_replay_seq", rep_seq, 0);
`else
    check("no_timer_replay", seen_rep, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
